// File: rtl/btn_conditioner.sv
// Purpose: synchronise, debounce and arbitrate the five push-buttons into a clean
//          zero-or-one-hot level code, a one-cycle acceptance pulse and a chord lockout flag.
// Latency: outputs follow a clean edge of btn_raw by DEBOUNCE_CYCLES+2 clocks.
//          There is no backpressure; the outputs are registered levels that the consumer samples freely.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   btn_raw    raw, bouncing, asynchronous button pins (bit 0 clear, bits 4:1 operations)
//   buttons    conditioned code: all-zero or exactly one-hot, held while the button is pressed
//   btn_pulse  one-cycle pulse on the bit just accepted
//   lockout    high while a multi-button chord is being rejected
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int N_BTN           = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] buttons,
  output logic [N_BTN-1:0] btn_pulse,
  output logic             lockout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LOCK = 2'd2
  } state_t;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] deb;
  logic [CW-1:0]    cnt [N_BTN];
  state_t           state;
  logic             deb_zero;
  logic             deb_onehot;

  // Two-flop synchroniser on every pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Per-bit debouncer: the counter only advances while the synchronised level
  // disagrees with the accepted level, so any bounce back restarts it from 0.
  // The level flips on the edge where the counter sits at its terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign deb_zero   = (deb == '0);
  // Clearing the lowest set bit leaves zero only for a single set bit.
  assign deb_onehot = !deb_zero && ((deb & (deb - N_BTN'(1))) == '0);

  // Arbiter. A chord (or a leftover press after the held one is released)
  // locks the outputs off until every button has been let go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      buttons   <= '0;
      btn_pulse <= '0;
      lockout   <= 1'b0;
    end else begin
      btn_pulse <= '0;
      case (state)
        IDLE: begin
          if (deb_onehot) begin
            state     <= HELD;
            buttons   <= deb;
            btn_pulse <= deb;
          end else if (!deb_zero) begin
            state   <= LOCK;
            lockout <= 1'b1;
          end
        end
        HELD: begin
          // Extra buttons pressed while one is held are simply ignored.
          if ((deb & buttons) == '0) begin
            buttons <= '0;
            if (deb_zero) begin
              state <= IDLE;
            end else begin
              state   <= LOCK;
              lockout <= 1'b1;
            end
          end
        end
        LOCK: begin
          buttons <= '0;
          if (deb_zero) begin
            state   <= IDLE;
            lockout <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          buttons   <= '0;
          lockout   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end conditioning stage for the five Basys3 push-buttons, sitting directly upstream of the calculator operation FSM. It synchronises the raw asynchronous button pins and debounces each one. It then arbitrates so that the FSM only ever sees either all-zero or a single clean one-hot code, held for as long as that button stays pressed. It also produces a one-cycle acceptance pulse per press and a lockout flag for illegal multi-button chords.

## Interface
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before a synchronised level is accepted (10 ms at 100 MHz); legal range 2 .. 2^24-1
- N_BTN, 5, number of buttons; fixed at 5 in this design, with bit 0 the reset/clear button and bits 4:1 the operation buttons
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  reset; one clock, reset asynchronous and active-low
- btn_raw  input  N_BTN  raw button pins, active-high, asynchronous and bouncing
- buttons  output  N_BTN  conditioned level code; either 0 or exactly one-hot; drives the FSM `buttons` input
- btn_pulse  output  N_BTN  one-cycle pulse on the bit just accepted
- lockout  output  1  high while a multi-button chord is being rejected

## Operation
- Synchroniser: two flops per bit; reset value 0.
- Debouncer, one per bit:
  - Holds a stable level `deb[i]` (reset 0) and a counter (reset 0), width `$clog2(DEBOUNCE_CYCLES)`.
  - If `sync[i] == deb[i]`, the counter clears.
  - Otherwise the counter increments. When it is at DEBOUNCE_CYCLES-1 and `sync[i]` still differs, `deb[i]` toggles on that edge and the counter clears.
  - Any bounce back to `deb[i]` before the terminal count restarts the count from 0.
- Arbiter FSM over the `deb` vector; states IDLE, HELD, LOCK; reset state IDLE.
  - IDLE:
    - `deb` == 0: stay.
    - `deb` exactly one-hot: go to HELD; latch the code into `buttons`; pulse the same bit on `btn_pulse`.
    - `deb` multi-hot: go to LOCK.
  - HELD:
    - The latched bit still set in `deb`: stay. `buttons` holds the code; any other bits that become pressed are ignored (no pulse, no change).
    - `deb` == 0: go to IDLE; `buttons` goes to 0.
    - Latched bit released while another bit is still set: go to LOCK; `buttons` goes to 0.
  - LOCK:
    - `buttons` = 0, `lockout` = 1.
    - Exit to IDLE only when `deb` == 0. A lone survivor bit never produces an acceptance; the user must release everything first.
- All three outputs are registered.
- `btn_pulse` is high for exactly one cycle per IDLE→HELD transition and never in any other state.
- Reset mid-operation: all state, counters, synchroniser flops and outputs return to 0 / IDLE immediately; no pulse is produced on release of reset.

## Timing
- Reset values: `buttons` = 0, `btn_pulse` = 0, `lockout` = 0, FSM in IDLE.
- Press latency: let edge 0 be the first clock edge that samples the new `btn_raw` level with no further bounce.
  - `sync` changes at edge 1.
  - `deb` changes at edge 1+DEBOUNCE_CYCLES.
  - `buttons` and `btn_pulse` update at edge 2+DEBOUNCE_CYCLES.
- Release latency is identical: `buttons` returns to 0 at edge 2+DEBOUNCE_CYCLES.
- Simultaneous debounce completion:
  - If two bits' `deb` toggle on the same edge from all-zero, the FSM sees multi-hot and goes to LOCK.
  - Bits whose `deb` completes one or more cycles apart: the first is accepted and later ones are ignored.
- Minimum press: a pulse shorter than DEBOUNCE_CYCLES synchronised cycles produces no output activity.
- Throughput: a new acceptance cannot occur earlier than DEBOUNCE_CYCLES+1 cycles after the previous release is registered.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: hold `rst_n`=0 with `btn_raw`=5'b00100 -> all outputs 0. Release `rst_n` with the button still held -> `buttons`=5'b00100 at edge 6 after release, one `btn_pulse`=5'b00100.
- Clean press/release of bit 1: `btn_raw`=5'b00010 at edge 0 -> `buttons`=5'b00010 and `btn_pulse`=5'b00010 at edge 6, pulse 0 at edge 7. Release -> `buttons`=0 at 6 edges later.
- Bounce rejection: bit 3 toggles 1,0,1,0,1 every 2 cycles, then stays 1 -> no output until 6 edges after the final stable 1, then exactly one pulse.
- Chord lockout:
  - Bits 2 and 4 rise on the same edge -> `lockout`=1, `buttons`=0, no pulse.
  - Release bit 2 only -> still locked.
  - Release bit 4 -> `lockout`=0.
  - Re-press bit 4 -> accepted normally.
- Second button while held: bit 1 accepted, then bit 4 pressed 20 cycles later -> `buttons` stays 5'b00010, no pulse. Release bit 1 -> `buttons`=0 and `lockout`=1 until bit 4 is released.
- Asynchronous reset while HELD at bit 0: assert `rst_n`=0 mid-cycle -> outputs 0 with no clock edge needed, and no pulse after reset is released if `btn_raw`=0.
